sdram_arbiter: RTL and testbench
================================

# sdram_arbiter

Request arbiter directly upstream of the single-port 8-bit SDRAM controller. It merges two clients onto the controller's edge-triggered oe/we interface: the CPU/chipset port (level request, acknowledged) and the ROM/cartridge download port (single-cycle write strobes, buffered in a small FIFO). All issue decisions are aligned to clkref slot boundaries, so each controller request is presented as a clean rising edge that is held stable for one full slot.

## Interface
- DL_DEPTH, 4, download FIFO depth; power of two, ≥2
- clk  in  1  system clock, same clock as the SDRAM controller
- reset  in  1  synchronous, active-high
- clkref  in  1  slot reference; its rising edge starts an 8-clk controller slot
- ram_ready  in  1  controller initialisation complete; no request is issued while low
- cpu_req  in  1  CPU request level; held until cpu_ack
- cpu_we  in  1  1=write, 0=read; stable while cpu_req
- cpu_addr  in  23  byte address
- cpu_bank  in  2  SDRAM bank
- cpu_din  in  8  write data
- cpu_dout  out  8  read data, valid from cpu_ack until the next read completes
- cpu_ack  out  1  one-clk pulse at completion
- dl_wr  in  1  one-clk download write strobe
- dl_addr  in  23  download byte address
- dl_bank  in  2  download bank
- dl_data  in  8  download byte
- dl_full  out  1  FIFO full; a dl_wr in this cycle is dropped
- dl_overflow  out  1  sticky; set when a dl_wr is dropped
- mem_oe, mem_we  out  1 each  to controller
- mem_addr  out  23;  mem_bank  out  2;  mem_din  out  8  to controller
- mem_dout  in  8  from controller

## Operation
- slot_start = clkref & ~clkref_d (one registered sample of clkref); it is the only cycle in which state or mem_* outputs may change.
- FSM states: IDLE, ACTIVE, GAP.
- IDLE: at slot_start with ram_ready=1 and a pending request → latch winner into mem_addr/mem_bank/mem_din, assert mem_oe (read) or mem_we (write), go ACTIVE.
- ACTIVE: held for exactly one slot. At the next slot_start: for a CPU read, capture mem_dout into cpu_dout; CPU winner → pulse cpu_ack; FIFO winner → pop; deassert mem_oe/mem_we; go GAP.
- GAP: outputs deasserted for one full slot, which guarantees a rising edge at the controller for the next request; at next slot_start behave as IDLE (may launch directly).
- Arbitration default: CPU has priority; FIFO is served only when cpu_req=0.
- A cpu_req already in service is not re-issued: cpu_ack is registered, and cpu_req seen in the cycle of cpu_ack is ignored.
- FIFO: push on dl_wr & ~dl_full; pop at ACTIVE completion; simultaneous push and pop leaves count unchanged. Count width $clog2(DL_DEPTH)+1; pointers wrap modulo DL_DEPTH.
- FIFO requests are always writes.
- mem_addr/mem_bank/mem_din stay at last values when idle; only mem_oe/mem_we return to 0.

## Timing
- Reset values: mem_oe=mem_we=0, mem_addr=0, mem_bank=0, mem_din=0, cpu_dout=0, cpu_ack=0, dl_full=0, dl_overflow=0; FIFO empty; FSM IDLE.
- Reset mid-operation: request aborted, no ack, FIFO flushed, IDLE next clk.
- Latency, idle arbiter: request issued at the first slot_start after cpu_req rises; cpu_ack exactly 8 clk after issue (one slot).
- Throughput: one access per two slots (16 clk).
- ram_ready falling mid-ACTIVE: current access completes normally; no new issue.
- dl_full asserted combinationally from count==DL_DEPTH.

## Configuration
- SDRAM_ARB_DL_PRIO_EN defined: FIFO has priority whenever non-empty; CPU waits. Intended for cold-start ROM loading with the CPU held.
- Undefined: CPU priority as above.

## Structure
- Package sdram_arb_pkg: state enum (IDLE, ACTIVE, GAP), request struct {addr[22:0], bank[1:0], data[7:0], we}, SLOT_CLKS=8.
- Sub-module sdram_dl_fifo: parameterised synchronous FIFO of request structs with push/pop/full/empty/count.

## Test plan
- CPU read, addr 0x000123, mem_dout 0x5A during ACTIVE → mem_oe high one slot, cpu_ack 8 clk after issue, cpu_dout=0x5A.
- Two back-to-back CPU writes → mem_we low for one full slot between them; second issued 16 clk after first.
- Five dl_wr strobes in five clk with DL_DEPTH=4 → dl_full after fourth, fifth dropped, dl_overflow=1, four writes issued in order.
- cpu_req while FIFO holds 2 entries → CPU served first (default); with SDRAM_ARB_DL_PRIO_EN, both FIFO writes first.
- ram_ready=0 with cpu_req high → no mem_oe; rising ram_ready → issue at next slot_start.
- reset asserted during ACTIVE → mem_oe=0 next clk, no cpu_ack, FIFO empty.

Source files
------------

// File: rtl/sdram_arb_pkg.sv
// Shared types for the SDRAM request arbiter.
package sdram_arb_pkg;

   localparam int unsigned SLOT_CLKS = 8;
   localparam int unsigned ADDR_W    = 23;
   localparam int unsigned BANK_W    = 2;
   localparam int unsigned DATA_W    = 8;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACTIVE = 2'd1,
      GAP    = 2'd2
   } state_e;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [BANK_W-1:0] bank;
      logic [DATA_W-1:0] data;
      logic              we;
   } req_t;

endpackage

// File: rtl/sdram_dl_fifo.sv
// Synchronous FIFO of download write requests; DEPTH must be a power of two.
module sdram_dl_fifo
   import sdram_arb_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push_i,
   input  req_t                     data_i,
   input  logic                     pop_i,
   output req_t                     data_c,
   output logic                     full_c,
   output logic                     empty_c,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   req_t             mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q;
   logic [PTR_W-1:0] rd_ptr_q;
   logic [CNT_W-1:0] count_q;
   logic             push_ok_c;
   logic             pop_ok_c;

   assign full_c    = (count_q == CNT_W'(DEPTH));
   assign empty_c   = (count_q == '0);
   assign push_ok_c = push_i & ~full_c;
   assign pop_ok_c  = pop_i & ~empty_c;
   assign data_c    = mem_q[rd_ptr_q];
   assign count_o   = count_q;

   // Storage array, written on accepted push only
   always_ff @(posedge clk) begin
      if (push_ok_c) begin
         mem_q[wr_ptr_q] <= data_i;
      end
   end

   // Pointers wrap naturally at DEPTH; push+pop together keeps count
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_ok_c) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (pop_ok_c)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         count_q <= count_q + CNT_W'(push_ok_c) - CNT_W'(pop_ok_c);
      end
   end

endmodule

// File: rtl/sdram_arbiter.sv
// CPU / download arbiter in front of the slot-based SDRAM controller.
// Optional build macro SDRAM_ARB_DL_PRIO_EN: download FIFO wins whenever
// non-empty (cold-start ROM loading); otherwise the CPU has priority.
module sdram_arbiter
   import sdram_arb_pkg::*;
#(
   parameter int unsigned DL_DEPTH = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        clkref,
   input  logic        ram_ready,
   input  logic        cpu_req,
   input  logic        cpu_we,
   input  logic [22:0] cpu_addr,
   input  logic [1:0]  cpu_bank,
   input  logic [7:0]  cpu_din,
   output logic [7:0]  cpu_dout,
   output logic        cpu_ack,
   input  logic        dl_wr,
   input  logic [22:0] dl_addr,
   input  logic [1:0]  dl_bank,
   input  logic [7:0]  dl_data,
   output logic        dl_full,
   output logic        dl_overflow,
   output logic        mem_oe,
   output logic        mem_we,
   output logic [22:0] mem_addr,
   output logic [1:0]  mem_bank,
   output logic [7:0]  mem_din,
   input  logic [7:0]  mem_dout
);

   localparam int unsigned CNT_W = $clog2(DL_DEPTH) + 1;

   state_e           state_q;
   req_t             mem_req_q;
   logic             clkref_d_q;
   logic             cpu_owner_q;
   logic             mem_oe_q;
   logic             mem_we_q;
   logic             cpu_ack_q;
   logic             dl_overflow_q;
   logic [7:0]       cpu_dout_q;

   logic             slot_start_c;
   logic             cpu_sel_c;
   logic             dl_sel_c;
   logic             dl_pop_c;
   logic             dl_full_c;
   logic             dl_empty_c;
   logic [CNT_W-1:0] dl_count;
   req_t             cpu_req_c;
   req_t             dl_push_c;
   req_t             dl_head_c;
   req_t             win_req_c;

   assign slot_start_c = clkref & ~clkref_d_q;
   assign cpu_req_c    = '{addr: cpu_addr, bank: cpu_bank, data: cpu_din, we: cpu_we};
   assign dl_push_c    = '{addr: dl_addr, bank: dl_bank, data: dl_data, we: 1'b1};
   assign dl_pop_c     = slot_start_c & (state_q == ACTIVE) & ~cpu_owner_q & ~dl_empty_c;

   sdram_dl_fifo #(
      .DEPTH   (DL_DEPTH)
   ) u_dl_fifo (
      .clk     (clk),
      .reset   (reset),
      .push_i  (dl_wr),
      .data_i  (dl_push_c),
      .pop_i   (dl_pop_c),
      .data_c  (dl_head_c),
      .full_c  (dl_full_c),
      .empty_c (dl_empty_c),
      .count_o (dl_count)
   );

   // Pick the next client to launch
   always_comb begin
      cpu_sel_c = 1'b0;
      dl_sel_c  = 1'b0;
`ifdef SDRAM_ARB_DL_PRIO_EN
      if (dl_count != '0) begin
         dl_sel_c = 1'b1;
      end else if (cpu_req) begin
         cpu_sel_c = 1'b1;
      end
`else
      if (cpu_req) begin
         cpu_sel_c = 1'b1;
      end else if (dl_count != '0) begin
         dl_sel_c = 1'b1;
      end
`endif
      win_req_c = cpu_sel_c ? cpu_req_c : dl_head_c;
   end

   // Slot-aligned issue FSM; every mem_* change happens on slot_start only
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= IDLE;
         mem_req_q     <= '0;
         clkref_d_q    <= 1'b0;
         cpu_owner_q   <= 1'b0;
         mem_oe_q      <= 1'b0;
         mem_we_q      <= 1'b0;
         cpu_ack_q     <= 1'b0;
         dl_overflow_q <= 1'b0;
         cpu_dout_q    <= '0;
      end else begin
         clkref_d_q <= clkref;
         cpu_ack_q  <= 1'b0;
         if (dl_wr && dl_full_c) begin
            dl_overflow_q <= 1'b1;
         end
         if (slot_start_c) begin
            case (state_q)
               ACTIVE: begin
                  if (cpu_owner_q) begin
                     cpu_ack_q <= 1'b1;
                     if (!mem_we_q) begin
                        cpu_dout_q <= mem_dout;
                     end
                  end
                  mem_oe_q <= 1'b0;
                  mem_we_q <= 1'b0;
                  state_q  <= GAP;
               end
               default: begin
                  if (ram_ready && (cpu_sel_c || dl_sel_c)) begin
                     mem_req_q   <= win_req_c;
                     mem_oe_q    <= ~win_req_c.we;
                     mem_we_q    <= win_req_c.we;
                     cpu_owner_q <= cpu_sel_c;
                     state_q     <= ACTIVE;
                  end else begin
                     state_q <= IDLE;
                  end
               end
            endcase
         end
      end
   end

   assign mem_oe      = mem_oe_q;
   assign mem_we      = mem_we_q;
   assign mem_addr    = mem_req_q.addr;
   assign mem_bank    = mem_req_q.bank;
   assign mem_din     = mem_req_q.data;
   assign cpu_ack     = cpu_ack_q;
   assign cpu_dout    = cpu_dout_q;
   assign dl_full     = dl_full_c;
   assign dl_overflow = dl_overflow_q;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter (honours SDRAM_ARB_DL_PRIO_EN ordering).
module tb_sdram_arbiter;
   import sdram_arb_pkg::*;

   localparam int SLOT = int'(SLOT_CLKS);

   logic        clk, reset, clkref, ram_ready;
   logic        cpu_req, cpu_we;
   logic [22:0] cpu_addr;
   logic [1:0]  cpu_bank;
   logic [7:0]  cpu_din, cpu_dout;
   logic        cpu_ack;
   logic        dl_wr;
   logic [22:0] dl_addr;
   logic [1:0]  dl_bank;
   logic [7:0]  dl_data;
   logic        dl_full, dl_overflow;
   logic        mem_oe, mem_we;
   logic [22:0] mem_addr;
   logic [1:0]  mem_bank;
   logic [7:0]  mem_din, mem_dout;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;
   int ph     = 0;

   sdram_arbiter #(.DL_DEPTH(4)) dut (
      .clk(clk), .reset(reset), .clkref(clkref), .ram_ready(ram_ready),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_bank(cpu_bank),
      .cpu_din(cpu_din), .cpu_dout(cpu_dout), .cpu_ack(cpu_ack),
      .dl_wr(dl_wr), .dl_addr(dl_addr), .dl_bank(dl_bank), .dl_data(dl_data),
      .dl_full(dl_full), .dl_overflow(dl_overflow),
      .mem_oe(mem_oe), .mem_we(mem_we), .mem_addr(mem_addr), .mem_bank(mem_bank),
      .mem_din(mem_din), .mem_dout(mem_dout)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   // clkref: high 4 clk, low 4 clk; slot edge is the posedge after ph becomes 0
   initial begin
      clkref = 1'b0;
      forever begin
         @(posedge clk);
         #2;
         ph     = (ph + 1) % SLOT;
         clkref = (ph < SLOT / 2);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic sel_val(input int sel);
      case (sel)
         0:       return mem_oe;
         1:       return mem_we;
         2:       return cpu_ack;
         3:       return mem_oe | mem_we;
         default: return mem_oe | mem_we | cpu_ack;
      endcase
   endfunction

   task automatic wait_lvl(input int sel, input logic val, input int max,
                           output int t, output bit ok);
      ok = 1'b0;
      t  = 0;
      for (int i = 0; i < max; i++) begin
         @(negedge clk);
         if (sel_val(sel) === val) begin
            ok = 1'b1;
            t  = cyc;
            break;
         end
      end
   endtask

   task automatic align();
      do @(negedge clk); while (ph != 1);
   endtask

   int          t0, t1, t2, tr;
   bit          ok;
   logic [22:0] exp_a [3];
   logic        exp_oe [3];

   initial begin
      reset = 1'b1; ram_ready = 1'b1;
      cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_bank = '0; cpu_din = '0;
      dl_wr = 1'b0; dl_addr = '0; dl_bank = '0; dl_data = '0;
      mem_dout = 8'h5A;
      repeat (3) @(negedge clk);

      // Reset values
      chk("rst_oe",   32'(mem_oe), 32'd0);
      chk("rst_we",   32'(mem_we), 32'd0);
      chk("rst_addr", 32'(mem_addr), 32'd0);
      chk("rst_dout", 32'(cpu_dout), 32'd0);
      chk("rst_ack",  32'(cpu_ack), 32'd0);
      chk("rst_full", 32'(dl_full), 32'd0);
      chk("rst_ovf",  32'(dl_overflow), 32'd0);
      reset = 1'b0;
      repeat (2) @(negedge clk);

      // CPU read
      cpu_we = 1'b0; cpu_addr = 23'h000123; cpu_bank = 2'd1; cpu_req = 1'b1;
      wait_lvl(0, 1'b1, 20, t0, ok);
      chk("rd_issue", 32'(ok), 32'd1);
      chk("rd_addr",  32'(mem_addr), 32'h123);
      chk("rd_bank",  32'(mem_bank), 32'd1);
      chk("rd_we",    32'(mem_we), 32'd0);
      wait_lvl(2, 1'b1, 20, t1, ok);
      chk("rd_ack_seen", 32'(ok), 32'd1);
      chk("rd_ack_lat",  t1 - t0, 32'd8);
      chk("rd_dout",     32'(cpu_dout), 32'h5A);
      chk("rd_oe_off",   32'(mem_oe), 32'd0);
      cpu_req = 1'b0;
      @(negedge clk);
      chk("rd_ack_pulse", 32'(cpu_ack), 32'd0);

      // Two back-to-back CPU writes
      cpu_we = 1'b1; cpu_addr = 23'h000AAA; cpu_din = 8'h11; cpu_req = 1'b1;
      wait_lvl(1, 1'b1, 30, t0, ok);
      chk("wr1_issue", 32'(ok), 32'd1);
      chk("wr1_din",   32'(mem_din), 32'h11);
      wait_lvl(2, 1'b1, 20, t1, ok);
      chk("wr1_ack_lat", t1 - t0, 32'd8);
      chk("wr1_we_off",  32'(mem_we), 32'd0);
      cpu_addr = 23'h000BBB; cpu_din = 8'h22;
      wait_lvl(1, 1'b1, 30, t2, ok);
      chk("wr2_issue",   32'(ok), 32'd1);
      chk("wr2_spacing", t2 - t0, 32'd16);
      chk("wr2_gap",     t2 - t1, 32'd8);
      chk("wr2_addr",    32'(mem_addr), 32'hBBB);
      chk("wr2_din",     32'(mem_din), 32'h22);
      wait_lvl(2, 1'b1, 20, t1, ok);
      chk("wr2_ack", 32'(ok), 32'd1);
      cpu_req = 1'b0; cpu_we = 1'b0;

      // Five download strobes into a depth-4 FIFO
      @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         dl_addr = 23'(32'h100 + i);
         dl_bank = 2'(i);
         dl_data = 8'(32'hA0 + i);
         dl_wr   = 1'b1;
         if (i == 3) chk("dl_notfull_3", 32'(dl_full), 32'd0);
         if (i == 4) chk("dl_full_4",    32'(dl_full), 32'd1);
         @(negedge clk);
      end
      dl_wr = 1'b0;
      chk("dl_ovf", 32'(dl_overflow), 32'd1);
      for (int k = 0; k < 4; k++) begin
         wait_lvl(1, 1'b1, 40, t0, ok);
         chk("dl_issue", 32'(ok), 32'd1);
         chk("dl_addr",  32'(mem_addr), 32'(32'h100 + k));
         chk("dl_data",  32'(mem_din), 32'(32'hA0 + k));
         chk("dl_bank",  32'(mem_bank), 32'(k % 4));
         wait_lvl(1, 1'b0, 20, t0, ok);
      end
      wait_lvl(3, 1'b1, 40, t0, ok);
      chk("dl_no_fifth",  32'(ok), 32'd0);
      chk("dl_drained",   32'(dl_full), 32'd0);
      chk("dl_ovf_stick", 32'(dl_overflow), 32'd1);

      // CPU request competing with two FIFO entries
`ifdef SDRAM_ARB_DL_PRIO_EN
      exp_a[0] = 23'h200; exp_a[1] = 23'h201; exp_a[2] = 23'h777;
      exp_oe[0] = 1'b0;   exp_oe[1] = 1'b0;   exp_oe[2] = 1'b1;
`else
      exp_a[0] = 23'h777; exp_a[1] = 23'h200; exp_a[2] = 23'h201;
      exp_oe[0] = 1'b1;   exp_oe[1] = 1'b0;   exp_oe[2] = 1'b0;
`endif
      align();
      cpu_we = 1'b0; cpu_addr = 23'h000777; cpu_req = 1'b1;
      dl_addr = 23'h200; dl_data = 8'hB0; dl_bank = 2'd0; dl_wr = 1'b1;
      @(negedge clk);
      dl_addr = 23'h201; dl_data = 8'hB1;
      @(negedge clk);
      dl_wr = 1'b0;
      for (int k = 0; k < 3; k++) begin
         wait_lvl(3, 1'b1, 40, t0, ok);
         chk("prio_issue", 32'(ok), 32'd1);
         chk("prio_addr",  32'(mem_addr), 32'(exp_a[k]));
         chk("prio_oe",    32'(mem_oe), 32'(exp_oe[k]));
         wait_lvl(3, 1'b0, 20, t0, ok);
         if (cpu_ack) cpu_req = 1'b0;
      end
      chk("prio_req_done", 32'(cpu_req), 32'd0);

      // ram_ready gating, and ram_ready falling mid-access
      mem_dout = 8'hC3;
      ram_ready = 1'b0;
      cpu_we = 1'b0; cpu_addr = 23'h000055; cpu_req = 1'b1;
      wait_lvl(0, 1'b1, 30, t0, ok);
      chk("rr_blocked", 32'(ok), 32'd0);
      align();
      ram_ready = 1'b1;
      tr = cyc;
      wait_lvl(0, 1'b1, 20, t0, ok);
      chk("rr_issue",     32'(ok), 32'd1);
      chk("rr_issue_lat", t0 - tr, 32'd8);
      ram_ready = 1'b0;
      wait_lvl(2, 1'b1, 20, t1, ok);
      chk("rr_ack_lat", t1 - t0, 32'd8);
      chk("rr_dout",    32'(cpu_dout), 32'hC3);
      cpu_req = 1'b0;
      ram_ready = 1'b1;

      // Reset in the middle of an access
      cpu_we = 1'b0; cpu_addr = 23'h0003C0; cpu_req = 1'b1;
      dl_addr = 23'h300; dl_data = 8'hD0; dl_wr = 1'b1;
      @(negedge clk);
      dl_wr = 1'b0;
      wait_lvl(3, 1'b1, 40, t0, ok);
      chk("rst_mid_issue", 32'(ok), 32'd1);
      repeat (3) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      chk("rst_mid_oe",   32'(mem_oe), 32'd0);
      chk("rst_mid_we",   32'(mem_we), 32'd0);
      chk("rst_mid_addr", 32'(mem_addr), 32'd0);
      chk("rst_mid_ack",  32'(cpu_ack), 32'd0);
      chk("rst_mid_ovf",  32'(dl_overflow), 32'd0);
      reset = 1'b0; cpu_req = 1'b0;
      wait_lvl(4, 1'b1, 40, t0, ok);
      chk("rst_mid_quiet", 32'(ok), 32'd0);
      chk("rst_mid_full",  32'(dl_full), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
